// File: rtl/rv32im_mem_arbiter_pkg.sv
// Shared definitions for the RV32IM memory arbiter: bus widths, FSM encoding,
// watchdog default and the latched memory-request payload.
package rv32im_mem_arbiter_pkg;

  localparam int unsigned API_ADDR_WIDTH  = 32;
  localparam int unsigned API_DATA_WIDTH  = 32;
  localparam int unsigned API_MASK_WIDTH  = 4;
  localparam int unsigned MEMARB_MAX_WAIT = 15;
  localparam int unsigned MEMARB_WAIT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [API_ADDR_WIDTH-1:0] addr;
    logic [API_MASK_WIDTH-1:0] wr_mask;
    logic [API_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  // Memory is word addressed: byte offset bits are dropped
  function automatic logic [API_ADDR_WIDTH-1:0] word_align(input logic [API_ADDR_WIDTH-1:0] addr);
    return addr & ~API_ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/rv32im_mem_arbiter_if.sv
// Request/response bundle between the fetch unit, load-store unit, shared memory
// and the arbiter. slave = arbiter view, master = requester/memory view.
interface rv32im_mem_arbiter_if;
  import rv32im_mem_arbiter_pkg::*;

  logic                      if_req_i;
  logic [API_ADDR_WIDTH-1:0] if_addr_i;
  logic [API_DATA_WIDTH-1:0] if_rdata_o;
  logic                      if_done_o;
  logic                      if_err_o;

  logic                      ls_req_i;
  logic [API_ADDR_WIDTH-1:0] ls_addr_i;
  logic [API_MASK_WIDTH-1:0] ls_wr_mask_i;
  logic [API_DATA_WIDTH-1:0] ls_wdata_i;
  logic [API_DATA_WIDTH-1:0] ls_rdata_o;
  logic                      ls_done_o;
  logic                      ls_err_o;

  logic [API_ADDR_WIDTH-1:0] mem_addr_o;
  logic [API_MASK_WIDTH-1:0] mem_wr_mask_o;
  logic [API_DATA_WIDTH-1:0] mem_wdata_o;
  logic                      mem_enable_o;
  logic [API_DATA_WIDTH-1:0] mem_rdata_i;
  logic                      mem_ready_i;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, ls_wr_mask_i, ls_wdata_i,
           mem_rdata_i, mem_ready_i,
    output if_rdata_o, if_done_o, if_err_o, ls_rdata_o, ls_done_o, ls_err_o,
           mem_addr_o, mem_wr_mask_o, mem_wdata_o, mem_enable_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_addr_i, ls_wr_mask_i, ls_wdata_i,
           mem_rdata_i, mem_ready_i,
    input  if_rdata_o, if_done_o, if_err_o, ls_rdata_o, ls_done_o, ls_err_o,
           mem_addr_o, mem_wr_mask_o, mem_wdata_o, mem_enable_o
  );

endinterface

// File: rtl/rv32im_memarb_wdog.sv
// Access watchdog: counts mem_ready-low cycles and flags the MAX_WAIT-th one.
module rv32im_memarb_wdog
  import rv32im_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MEMARB_MAX_WAIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_c
);

  logic [MEMARB_WAIT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + MEMARB_WAIT_W'(1);
    end
  end

  // Fires in the cycle whose increment would make the count reach MAX_WAIT
  assign expired_c = inc_i && (count_q == MEMARB_WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/rv32im_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one shared memory port.
// Define MEMARB_RR_EN for round-robin on simultaneous requests; default is fixed LS priority.
module rv32im_mem_arbiter
  import rv32im_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MEMARB_MAX_WAIT
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rv32im_mem_arbiter_if.slave bus
);

  arb_state_e                state_q, state_d;
  mem_req_t                  mem_q, mem_d;
  logic                      mem_en_q, mem_en_d;
  logic                      grant_ls_q, grant_ls_d;
  logic [API_DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic                      if_done_q, if_done_d, if_err_q, if_err_d;
  logic                      ls_done_q, ls_done_d, ls_err_q, ls_err_d;
  logic                      any_req_c, pick_ls_c, prio_ls_c;
  logic                      wd_clear_c, wd_inc_c, wd_expired_c;
  mem_req_t                  if_req_c, ls_req_c;

  assign any_req_c  = bus.if_req_i || bus.ls_req_i;
  assign pick_ls_c  = bus.ls_req_i && (!bus.if_req_i || prio_ls_c);
  assign wd_clear_c = (state_q == ST_IDLE) && any_req_c;
  assign wd_inc_c   = (state_q == ST_ACCESS) && !bus.mem_ready_i;

  assign if_req_c = '{addr: word_align(bus.if_addr_i), wr_mask: '0, wdata: '0};
  assign ls_req_c = '{addr: word_align(bus.ls_addr_i), wr_mask: bus.ls_wr_mask_i,
                      wdata: bus.ls_wdata_i};

`ifdef MEMARB_RR_EN
  logic last_ls_q;

  // Remember who was granted so a tie goes to the other requester
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_ls_q <= 1'b0;
    end else if (wd_clear_c) begin
      last_ls_q <= pick_ls_c;
    end
  end

  assign prio_ls_c = !last_ls_q;
`else
  assign prio_ls_c = 1'b1;
`endif

  rv32im_memarb_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear_c),
    .inc_i     (wd_inc_c),
    .expired_c (wd_expired_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_d    = state_q;
    mem_d      = '0;
    mem_en_d   = 1'b0;
    grant_ls_d = grant_ls_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    ls_done_d  = 1'b0;
    ls_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          grant_ls_d = pick_ls_c;
          mem_d      = pick_ls_c ? ls_req_c : if_req_c;
          mem_en_d   = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_ready_i || wd_expired_c) begin
          state_d = ST_RESP;
          if (grant_ls_q) begin
            ls_rdata_d = bus.mem_ready_i ? bus.mem_rdata_i : '0;
            ls_done_d  = 1'b1;
            ls_err_d   = !bus.mem_ready_i;
          end else begin
            if_rdata_d = bus.mem_ready_i ? bus.mem_rdata_i : '0;
            if_done_d  = 1'b1;
            if_err_d   = !bus.mem_ready_i;
          end
        end else begin
          mem_d    = mem_q;
          mem_en_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q      <= '0;
      mem_en_q   <= 1'b0;
      grant_ls_q <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      ls_done_q  <= 1'b0;
      ls_err_q   <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      mem_en_q   <= mem_en_d;
      grant_ls_q <= grant_ls_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      ls_done_q  <= ls_done_d;
      ls_err_q   <= ls_err_d;
    end
  end

  assign bus.mem_addr_o    = mem_q.addr;
  assign bus.mem_wr_mask_o = mem_q.wr_mask;
  assign bus.mem_wdata_o   = mem_q.wdata;
  assign bus.mem_enable_o  = mem_en_q;
  assign bus.if_rdata_o    = if_rdata_q;
  assign bus.if_done_o     = if_done_q;
  assign bus.if_err_o      = if_err_q;
  assign bus.ls_rdata_o    = ls_rdata_q;
  assign bus.ls_done_o     = ls_done_q;
  assign bus.ls_err_o      = ls_err_q;

endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// Directed, table-driven bench for rv32im_mem_arbiter (default MAX_WAIT = 15).
module tb_rv32im_mem_arbiter;

  localparam int NEVER = 255;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          ready_after;
    logic [31:0] mem_rdata;
    logic [31:0] exp_addr;
    int          exp_en;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_if_rd, exp_ls_rd;

  rv32im_mem_arbiter_if bus ();

  rv32im_mem_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request through the full IDLE/ACCESS/RESP cycle; cycle 1 is the IDLE sample cycle
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, en_cnt, done_cyc, other_done;
    logic hold_bad;
    logic [31:0] a_addr, a_mask, a_wdata, exp_mask, exp_wdata, rd, err, o_err;
    cyc = 1; en_cnt = 0; done_cyc = 0; other_done = 0; hold_bad = 1'b0;
    a_addr = '0; a_mask = '0; a_wdata = '0; rd = '0; err = '0; o_err = '0;
    exp_mask  = v.is_ls ? 32'(v.mask) : 32'h0;
    exp_wdata = v.is_ls ? v.wdata : 32'h0;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    if (v.is_ls) begin
      bus.ls_req_i = 1'b1; bus.ls_addr_i = v.addr;
      bus.ls_wr_mask_i = v.mask; bus.ls_wdata_i = v.wdata;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = v.addr;
    end
    while (done_cyc == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_enable_o) begin
        en_cnt++;
        if (en_cnt == 1) begin
          a_addr = bus.mem_addr_o; a_mask = 32'(bus.mem_wr_mask_o); a_wdata = bus.mem_wdata_o;
          bus.if_addr_i = ~bus.if_addr_i; bus.ls_addr_i = ~bus.ls_addr_i;
          bus.ls_wr_mask_i = ~bus.ls_wr_mask_i; bus.ls_wdata_i = ~bus.ls_wdata_i;
        end else if (bus.mem_addr_o !== a_addr || 32'(bus.mem_wr_mask_o) !== a_mask ||
                     bus.mem_wdata_o !== a_wdata) begin
          hold_bad = 1'b1;
        end
        bus.mem_ready_i = (v.ready_after != NEVER) && (en_cnt > v.ready_after);
        bus.mem_rdata_i = bus.mem_ready_i ? v.mem_rdata : 32'h5A5A_A5A5;
      end else begin
        bus.mem_ready_i = 1'b0;
      end
      if (v.is_ls ? bus.if_done_o : bus.ls_done_o) other_done++;
      if (v.is_ls ? bus.ls_done_o : bus.if_done_o) begin
        done_cyc = cyc;
        rd    = v.is_ls ? bus.ls_rdata_o : bus.if_rdata_o;
        err   = 32'(v.is_ls ? bus.ls_err_o : bus.if_err_o);
        o_err = 32'(v.is_ls ? bus.if_err_o : bus.ls_err_o);
        chk({tag, " enable_in_resp"}, 32'(bus.mem_enable_o), 32'h0);
      end
    end
    bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0; bus.mem_ready_i = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    chk({tag, " mem_addr"}, a_addr, v.exp_addr);
    chk({tag, " mem_wr_mask"}, a_mask, exp_mask);
    chk({tag, " mem_wdata"}, a_wdata, exp_wdata);
    chk({tag, " access_cycles"}, 32'(en_cnt), 32'(v.exp_en));
    chk({tag, " bus_hold"}, 32'(hold_bad), 32'h0);
    chk({tag, " rdata"}, rd, v.exp_rdata);
    chk({tag, " err"}, err, 32'(v.exp_err));
    chk({tag, " other_err"}, o_err, 32'h0);
    chk({tag, " other_done"}, 32'(other_done), 32'h0);
    chk({tag, " other_rdata"}, v.is_ls ? bus.if_rdata_o : bus.ls_rdata_o,
        v.is_ls ? exp_if_rd : exp_ls_rd);
    if (v.is_ls) exp_ls_rd = v.exp_rdata;
    else         exp_if_rd = v.exp_rdata;
    @(negedge clk);
    chk({tag, " done_pulse_width"}, 32'(v.is_ls ? bus.ls_done_o : bus.if_done_o), 32'h0);
  endtask

  vec_t vecs [7];
  vec_t post;
  logic grants [8];
  int ng, dn, guard, n, dones;
  logic prev_en;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0106, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, 32'h0000_0104, 1, 3, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h2000_0012, 4'b0100, 32'h00AB_0000, 2, 32'h1111_2222, 32'h2000_0010, 3, 5, 1'b0, 32'h1111_2222};
    vecs[2] = '{1'b1, 32'h0000_0FFF, 4'h0, 32'h0, 14, 32'hCAFE_F00D, 32'h0000_0FFC, 15, 17, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'h0000_0040, 4'h0, 32'h0, NEVER, 32'h7777_7777, 32'h0000_0040, 15, 17, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1, 32'h0123_4567, 32'hFFFF_FFFC, 2, 4, 1'b0, 32'h0123_4567};
    vecs[5] = '{1'b1, 32'h8000_0003, 4'hF, 32'hA5A5_5A5A, 0, 32'h0BAD_F00D, 32'h8000_0000, 1, 3, 1'b0, 32'h0BAD_F00D};
    vecs[6] = '{1'b0, 32'h0000_1000, 4'h0, 32'h0, NEVER, 32'h9999_9999, 32'h0000_1000, 15, 17, 1'b1, 32'h0};
    post    = '{1'b0, 32'h0000_0208, 4'h0, 32'h0, 3, 32'h1357_2468, 32'h0000_0208, 4, 6, 1'b0, 32'h1357_2468};

    rst = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.ls_req_i = 1'b0; bus.ls_addr_i = '0; bus.ls_wr_mask_i = '0; bus.ls_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ready_i = 1'b0;
    exp_if_rd = '0; exp_ls_rd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ctrl_outputs", {22'h0, bus.mem_enable_o, bus.mem_wr_mask_o, bus.if_done_o,
        bus.if_err_o, bus.ls_done_o, bus.ls_err_o, 1'b0}, 32'h0);
    chk("reset mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset mem_wdata", bus.mem_wdata_o, 32'h0);
    chk("reset if_rdata", bus.if_rdata_o, 32'h0);
    chk("reset ls_rdata", bus.ls_rdata_o, 32'h0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: each requester drops its request once served
    ng = 0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0100;
      bus.ls_req_i = 1'b1; bus.ls_addr_i = 32'h0000_0200;
      bus.ls_wr_mask_i = 4'h0; bus.ls_wdata_i = 32'h0;
      dn = 0; guard = 0; prev_en = 1'b0;
      while (dn < 2 && guard < 30) begin
        @(negedge clk);
        guard++;
        if (bus.mem_enable_o && !prev_en && ng < 8) begin
          grants[ng] = (bus.mem_addr_o == 32'h0000_0200);
          ng++;
        end
        prev_en = bus.mem_enable_o;
        bus.mem_ready_i = bus.mem_enable_o;
        bus.mem_rdata_i = {16'hD00D, bus.mem_addr_o[15:0]};
        if (bus.if_done_o) begin bus.if_req_i = 1'b0; dn++; end
        if (bus.ls_done_o) begin bus.ls_req_i = 1'b0; dn++; end
      end
      bus.mem_ready_i = 1'b0;
    end
    chk("simul grant_count", 32'(ng), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("simul grant%0d_is_ls", i), 32'(grants[i]), 32'((i % 2) == 0));
    exp_if_rd = 32'hD00D_0100;
    exp_ls_rd = 32'hD00D_0200;
    chk("simul if_rdata", bus.if_rdata_o, exp_if_rd);
    chk("simul ls_rdata", bus.ls_rdata_o, exp_ls_rd);

    // Reset in the middle of a stalled access
    @(negedge clk);
    bus.ls_req_i = 1'b1; bus.ls_addr_i = 32'h0000_0300;
    bus.ls_wr_mask_i = 4'hF; bus.ls_wdata_i = 32'h1234_5678; bus.mem_ready_i = 1'b0;
    n = 0; guard = 0;
    while (n < 3 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (bus.mem_enable_o) n++;
    end
    chk("rst_mid access_seen", 32'(n), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid mem_enable", 32'(bus.mem_enable_o), 32'h0);
    chk("rst_mid mem_wr_mask", 32'(bus.mem_wr_mask_o), 32'h0);
    chk("rst_mid mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mid ls_done_err", {30'h0, bus.ls_done_o, bus.ls_err_o}, 32'h0);
    rst = 1'b0; bus.ls_req_i = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ls_done_o || bus.if_done_o) dones++;
    end
    chk("rst_mid no_done", 32'(dones), 32'h0);
    exp_if_rd = '0; exp_ls_rd = '0;
    chk("rst_mid if_rdata", bus.if_rdata_o, exp_if_rd);
    chk("rst_mid ls_rdata", bus.ls_rdata_o, exp_ls_rd);
    run_vec(post, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32im_mem_arbiter.md
RV32IM_MEM_ARBITER -- requirements
Module: rv32im_mem_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WAIT, default 15, maximum mem_ready_i-low cycles tolerated per access before abort (1..255).
REQ-002 SHALL have port: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: if_req_i  in  1 / if_addr_i  in  API_ADDR_WIDTH  instruction-fetch read request and byte address.
REQ-005 SHALL have ports: if_rdata_o  out  API_DATA_WIDTH / if_done_o  out  1 / if_err_o  out  1  fetch response.
REQ-006 SHALL have ports: ls_req_i  in  1 / ls_addr_i  in  API_ADDR_WIDTH / ls_wr_mask_i  in  4 / ls_wdata_i  in  API_DATA_WIDTH  load-store request; mask 0 = read, nonzero = byte-lane write.
REQ-007 SHALL have ports: ls_rdata_o  out  API_DATA_WIDTH / ls_done_o  out  1 / ls_err_o  out  1  load-store response.
REQ-008 SHALL have ports: mem_addr_o  out  API_ADDR_WIDTH / mem_wr_mask_o  out  4 / mem_wdata_o  out  API_DATA_WIDTH / mem_enable_o  out  1  shared memory port.
REQ-009 SHALL have ports: mem_rdata_i  in  API_DATA_WIDTH / mem_ready_i  in  1  memory response; ready high = access completes this cycle.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-011 IDLE: on any request, SHALL grant one requester, latch its address, mask, wdata (IF mask forced 4'b0000), go to ACCESS next cycle; no request -> stay IDLE.
REQ-012 Both requests in same IDLE cycle: load-store SHALL win (fixed priority) unless MEMARB_RR_EN is defined.
REQ-013 ACCESS: mem_enable_o=1; mem_addr_o = latched address with bits [1:0] forced 2'b00; mem_wr_mask_o, mem_wdata_o = latched values.
REQ-014 ACCESS with mem_ready_i=1: SHALL register mem_rdata_i into the granted requester's rdata output, go to RESP.
REQ-015 ACCESS with mem_ready_i=0: wait counter SHALL increment; when counter equals MAX_WAIT, SHALL abort to RESP with err flag set, rdata loaded with 0.
REQ-016 RESP: granted requester's done_o=1 (and err_o=1 if aborted) for exactly one cycle; next state IDLE; requests ignored in RESP.
REQ-017 Minimum access latency SHALL be 3 cycles from request sampled in IDLE to done (ready in first ACCESS cycle).
REQ-018 rdata outputs SHALL hold last value until the next completion for that requester.
REQ-019 Outside ACCESS, mem_enable_o, mem_wr_mask_o, mem_addr_o, mem_wdata_o SHALL be 0.
REQ-020 Requesters SHALL hold req/addr/data stable until done; arbiter SHALL ignore changes after latching.
REQ-021 Wait counter SHALL clear on entry to ACCESS; width 8 bits.

Reset
REQ-022 rst_i=1 at any edge, including mid-ACCESS, SHALL force IDLE, counter 0, all outputs 0, last-grant = IF; in-flight access dropped with no done.

Configuration
REQ-023 MEMARB_RR_EN defined: on simultaneous requests, SHALL grant the requester not granted last (last-grant register updated on each grant); undefined: fixed LS priority, no last-grant register.

Structure
REQ-024 State encodings and MEMARB_MAX_WAIT default SHALL live in the shared DEFINITIONS header alongside API_*_WIDTH.
REQ-025 Wait counter with terminal-count flag SHALL be sub-module rv32im_memarb_wdog.

Verification
REQ-026 IF read 0x0000_0106, mem_ready_i=1 first ACCESS cycle, rdata 0xDEAD_BEEF -> mem_addr_o 0x0000_0104, if_done_o one cycle at cycle 3, if_rdata_o 0xDEAD_BEEF.
REQ-027 LS write mask 4'b0100, wdata 0x00AB_0000, ready after 2 wait cycles -> mem_wr_mask_o 4'b0100 for 3 cycles, ls_done_o once, ls_err_o 0.
REQ-028 Simultaneous IF+LS, repeated 4 times -> fixed: LS,IF each pair LS first; RR_EN: LS,IF,LS,IF alternating grants.
REQ-029 mem_ready_i held 0, MAX_WAIT=15 -> abort after 15 wait cycles, ls_err_o=1 and ls_done_o=1 one cycle, ls_rdata_o 0.
REQ-030 rst_i asserted during ACCESS -> next cycle IDLE, mem_enable_o 0, no done pulse; new request afterwards served normally.
